fc_mp_refresh: RTL



---
 rtl/fc_mp_refresh_pkg.sv | 18 +
 rtl/fc_mp_refresh_if.sv | 26 ++
 rtl/fc_mp_mem.sv | 24 ++
 rtl/fc_mp_refresh.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/fc_mp_refresh_pkg.sv
// Shared widths, FSM state and spike-event record for the FC membrane-potential refresh stage.
package fc_mp_refresh_pkg;

  localparam int MP_WIDE      = 8;
  localparam int CHANNEL_WIDE = 8;
  localparam int MP_ACC_WIDE  = 16;

  typedef enum logic {
    ST_RUN,
    ST_CLEAR
  } state_e;

  typedef struct packed {
    logic                    fire;
    logic [CHANNEL_WIDE-1:0] channel;
  } spike_evt_t;

endpackage

// File: rtl/fc_mp_refresh_if.sv
// Weight stream in, spike events out; the PE side is the master.
interface fc_mp_refresh_if;
  import fc_mp_refresh_pkg::*;

  logic signed [MP_WIDE-1:0] mp_in;
  logic                      mp_valid;
  logic [CHANNEL_WIDE-1:0]   channel_num;
  logic                      mp_flush;
  logic                      mp_clear;
  logic                      in_ready;
  logic                      spike_valid;
  logic                      spike;
  logic [CHANNEL_WIDE-1:0]   spike_channel;
  logic                      layer_done;

  modport master (
    output mp_in, mp_valid, channel_num, mp_flush, mp_clear,
    input  in_ready, spike_valid, spike, spike_channel, layer_done
  );

  modport slave (
    input  mp_in, mp_valid, channel_num, mp_flush, mp_clear,
    output in_ready, spike_valid, spike, spike_channel, layer_done
  );

endinterface

// File: rtl/fc_mp_mem.sv
// Membrane-potential register file: asynchronous read, synchronous write.
module fc_mp_mem #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 16,
  parameter int AW    = 8
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [AW-1:0]           waddr,
  input  logic signed [WIDTH-1:0] wdata,
  input  logic [AW-1:0]           raddr,
  output logic signed [WIDTH-1:0] rdata
);

  logic signed [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: storage arrays get no reset; an explicit clear pass zeroes them instead.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fc_mp_refresh.sv
// Per-channel weight accumulation, integrate/leak/threshold into stored potentials, spike emission.
module fc_mp_refresh
  import fc_mp_refresh_pkg::*;
#(
  parameter int          OUTPUT_CHANNEL_NUM = 256,
  parameter int          ACC_WIDE           = MP_ACC_WIDE,
  parameter int          THRESHOLD          = 100,
  parameter int unsigned LEAK               = 0
) (
  input  logic            clk,
  input  logic            rstn,
  fc_mp_refresh_if.slave  bus
);

  localparam int MAW = (OUTPUT_CHANNEL_NUM > 1) ? $clog2(OUTPUT_CHANNEL_NUM) : 1;
  localparam int SW  = ACC_WIDE + 2;

  typedef logic signed [ACC_WIDE-1:0] acc_t;

  localparam logic signed [SW-1:0] SAT_MAX = SW'((longint'(1) << (ACC_WIDE - 1)) - 1);
  localparam logic signed [SW-1:0] SAT_MIN = SW'(-(longint'(1) << (ACC_WIDE - 1)));
  localparam logic signed [SW-1:0] LEAK_S  = SW'(LEAK);

  function automatic acc_t sat(input logic signed [SW-1:0] x);
    if (x > SAT_MAX) return acc_t'(SAT_MAX);
    if (x < SAT_MIN) return acc_t'(SAT_MIN);
    return acc_t'(x);
  endfunction

  state_e                  state_q, state_d;
  logic                    open_q, open_d;
  logic [CHANNEL_WIDE-1:0] cur_ch_q, cur_ch_d;
  acc_t                    acc_q, acc_d;
  logic                    flush_pend_q, flush_pend_d;
  logic [MAW-1:0]          clr_cnt_q, clr_cnt_d;
  logic                    spike_valid_q, spike_valid_d;
  logic                    layer_done_q, layer_done_d;
  spike_evt_t              evt_q, evt_d;

  logic                    mem_we;
  logic [MAW-1:0]          mem_waddr;
  acc_t                    mem_wdata;
  acc_t                    mem_rdata;

  acc_t                    in_ext;
  logic                    ch_ok;
  logic signed [SW-1:0]    v_sum;
  acc_t                    v_sat;
  logic                    fire;
  logic                    finalize;

  fc_mp_mem #(
    .DEPTH (OUTPUT_CHANNEL_NUM),
    .WIDTH (ACC_WIDE),
    .AW    (MAW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (cur_ch_q[MAW-1:0]),
    .rdata (mem_rdata)
  );

  if (OUTPUT_CHANNEL_NUM >= (1 << CHANNEL_WIDE)) begin : g_ch_all
    assign ch_ok = 1'b1;
  end else begin : g_ch_chk
    assign ch_ok = (int'(bus.channel_num) < OUTPUT_CHANNEL_NUM);
  end

  assign in_ext = acc_t'(bus.mp_in);

  // The finalize datapath always works on the open channel; the read port is tied to cur_ch.
  assign v_sum = SW'(mem_rdata) + SW'(acc_q) - LEAK_S;
  assign v_sat = sat(v_sum);
  assign fire  = (int'(v_sat) >= THRESHOLD);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d       = state_q;
    open_d        = open_q;
    cur_ch_d      = cur_ch_q;
    acc_d         = acc_q;
    flush_pend_d  = flush_pend_q;
    clr_cnt_d     = clr_cnt_q;
    spike_valid_d = 1'b0;
    layer_done_d  = 1'b0;
    evt_d         = evt_q;
    finalize      = 1'b0;
    mem_we        = 1'b0;
    mem_waddr     = cur_ch_q[MAW-1:0];
    mem_wdata     = fire ? '0 : v_sat;

    if (bus.mp_clear) begin
      state_d      = ST_CLEAR;
      clr_cnt_d    = '0;
      open_d       = 1'b0;
      flush_pend_d = 1'b0;
      acc_d        = '0;
    end else if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt_q;
      mem_wdata = '0;
      if (int'(clr_cnt_q) == OUTPUT_CHANNEL_NUM - 1) state_d = ST_RUN;
      else                                           clr_cnt_d = clr_cnt_q + 1'b1;
    end else begin
      if (bus.mp_valid) begin
        // A flush arriving with data waits for the first idle cycle so this sample is included.
        flush_pend_d = flush_pend_q | bus.mp_flush;
        if (ch_ok) begin
          if (!open_q) begin
            open_d   = 1'b1;
            cur_ch_d = bus.channel_num;
            acc_d    = in_ext;
          end else if (bus.channel_num == cur_ch_q) begin
            acc_d = sat(SW'(acc_q) + SW'(in_ext));
          end else begin
            finalize = 1'b1;
            cur_ch_d = bus.channel_num;
            acc_d    = in_ext;
          end
        end
      end else if (bus.mp_flush || flush_pend_q) begin
        flush_pend_d = 1'b0;
        layer_done_d = 1'b1;
        if (open_q) begin
          finalize = 1'b1;
          open_d   = 1'b0;
        end
      end

      if (finalize) begin
        mem_we        = 1'b1;
        spike_valid_d = 1'b1;
        evt_d         = '{fire: fire, channel: cur_ch_q};
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_RUN;
      open_q        <= 1'b0;
      cur_ch_q      <= '0;
      acc_q         <= '0;
      flush_pend_q  <= 1'b0;
      clr_cnt_q     <= '0;
      spike_valid_q <= 1'b0;
      layer_done_q  <= 1'b0;
      evt_q         <= '0;
    end else begin
      state_q       <= state_d;
      open_q        <= open_d;
      cur_ch_q      <= cur_ch_d;
      acc_q         <= acc_d;
      flush_pend_q  <= flush_pend_d;
      clr_cnt_q     <= clr_cnt_d;
      spike_valid_q <= spike_valid_d;
      layer_done_q  <= layer_done_d;
      evt_q         <= evt_d;
    end
  end

  assign bus.in_ready      = (state_q == ST_RUN);
  assign bus.spike_valid   = spike_valid_q;
  assign bus.spike         = evt_q.fire;
  assign bus.spike_channel = evt_q.channel;
  assign bus.layer_done    = layer_done_q;

endmodule
